// File: rtl/decoder_scan_nx2n_pkg.sv
// Shared types and helpers for the N-to-2^N scan decoder.
// Holds the FSM state type, the mode encodings and the one-hot helper.
// The one-hot helper covers select codes up to 8 bits wide, so N <= 8.
package decoder_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int ONEHOT_IDX_W = 8;
    localparam int ONEHOT_W     = 256;

    // Returns a vector with only bit idx_i set; callers size-cast it to their width.
    function automatic logic [ONEHOT_W-1:0] onehot(input logic [ONEHOT_IDX_W-1:0] idx_i);
        logic [ONEHOT_W-1:0] vec;
        vec = {{(ONEHOT_W-1){1'b0}}, 1'b1} << idx_i;
        return vec;
    endfunction

endpackage

// File: rtl/decoder_scan_nx2n_if.sv
// Select/output bundle of the scan decoder.
// The master side drives the select and the scan controls; the slave side is the decoder.
interface decoder_scan_nx2n_if #(
    parameter int N      = 3,
    parameter int HOLD_W = 8
);
    logic                en;
    logic                mode;
    logic                sel_valid;
    logic                sel_ready;
    logic [N-1:0]        sel;
    logic [HOLD_W-1:0]   hold;
    logic [(1<<N)-1:0]   y;
    logic [N-1:0]        idx;
    logic                y_valid;
    logic                wrap;

    modport master (
        output en, mode, sel_valid, sel, hold,
        input  sel_ready, y, idx, y_valid, wrap
    );

    modport slave (
        input  en, mode, sel_valid, sel, hold,
        output sel_ready, y, idx, y_valid, wrap
    );
endinterface

// File: rtl/decoder_scan_nx2n_dwell_cnt.sv
// Dwell counter for the scan mode of decoder_scan_nx2n.
// Captures max(hold,1) on scan entry and pulses step on the last cycle
// of each line's dwell, so every line stays active for hold_q cycles.
module dec_dwell_cnt #(
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              run,
    input  logic [HOLD_W-1:0] hold,
    output logic              step
);

    logic [HOLD_W-1:0] hold_q_r;
    logic [HOLD_W-1:0] cnt_r;

    // Last cycle of the current dwell; hold_q_r is never zero so the subtraction cannot wrap.
    assign step = run & (cnt_r == (hold_q_r - HOLD_W'(1'b1)));

    // Dwell register and count: reload on scan entry, restart after each step.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= {HOLD_W{1'b0}};
            hold_q_r <= HOLD_W'(1'b1);
        end else if (load) begin
            cnt_r    <= {HOLD_W{1'b0}};
            hold_q_r <= (hold == {HOLD_W{1'b0}}) ? HOLD_W'(1'b1) : hold;
        end else if (step) begin
            cnt_r    <= {HOLD_W{1'b0}};
        end else if (run) begin
            cnt_r    <= cnt_r + HOLD_W'(1'b1);
        end else begin
            cnt_r    <= cnt_r;
        end
    end

endmodule

// File: rtl/decoder_scan_nx2n.sv
// Registered N-to-2^N one-hot decoder with direct select and auto-scan modes.
// Direct mode decodes each accepted select code one cycle later; scan mode
// walks the active line through all 2^N outputs with a programmable dwell.
// Optional build macro DEC_INV_OUT_EN drives y active-low (idle value all ones).
module decoder_scan_nx2n
    import decoder_scan_pkg::*;
#(
    parameter int N      = 3,
    parameter int HOLD_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    decoder_scan_nx2n_if.slave  bus
);

    localparam int W = 1 << N;

`ifdef DEC_INV_OUT_EN
    localparam logic [W-1:0] Y_OFF = {W{1'b1}};
`else
    localparam logic [W-1:0] Y_OFF = {W{1'b0}};
`endif

    state_e         state_r;
    state_e         state_next_s;
    logic [N-1:0]   idx_r;
    logic [N-1:0]   idx_next_s;
    logic           y_valid_r;
    logic           y_valid_next_s;
    logic           wrap_r;
    logic           wrap_next_s;
    logic [W-1:0]   y_r;
    logic [W-1:0]   y_next_s;
    logic [W-1:0]   onehot_s;
    logic           load_s;
    logic           step_s;

    assign bus.sel_ready = bus.en & (bus.mode == MODE_DIRECT);
    assign bus.y         = y_r;
    assign bus.idx       = idx_r;
    assign bus.y_valid   = y_valid_r;
    assign bus.wrap      = wrap_r;

    dec_dwell_cnt #(.HOLD_W(HOLD_W)) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .load (load_s),
        .run  (state_r == SCAN),
        .hold (bus.hold),
        .step (step_s)
    );

    // Next state and next output values; en low dominates, then mode, then select.
    always_comb begin
        state_next_s   = state_r;
        idx_next_s     = idx_r;
        y_valid_next_s = y_valid_r;
        wrap_next_s    = 1'b0;
        load_s         = 1'b0;
        if (!bus.en) begin
            state_next_s   = IDLE;
            y_valid_next_s = 1'b0;
        end else if (bus.mode == MODE_SCAN) begin
            if (state_r == SCAN) begin
                if (step_s) begin
                    idx_next_s  = idx_r + N'(1'b1);
                    wrap_next_s = (idx_r == {N{1'b1}});
                end else begin
                    idx_next_s  = idx_r;
                end
            end else begin
                state_next_s   = SCAN;
                idx_next_s     = {N{1'b0}};
                y_valid_next_s = 1'b1;
                load_s         = 1'b1;
            end
        end else begin
            if (bus.sel_valid) begin
                state_next_s   = DIRECT;
                idx_next_s     = bus.sel;
                y_valid_next_s = 1'b1;
            end else if (state_r == SCAN) begin
                state_next_s   = IDLE;
                y_valid_next_s = 1'b0;
            end else begin
                state_next_s   = state_r;
            end
        end
    end

    // Output line pattern derived from the next index so y tracks idx in the same cycle.
    always_comb begin
        onehot_s = W'(onehot(ONEHOT_IDX_W'(idx_next_s)));
        if (y_valid_next_s) begin
`ifdef DEC_INV_OUT_EN
            y_next_s = ~onehot_s;
`else
            y_next_s = onehot_s;
`endif
        end else begin
            y_next_s = Y_OFF;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            idx_r     <= {N{1'b0}};
            y_valid_r <= 1'b0;
            wrap_r    <= 1'b0;
            y_r       <= Y_OFF;
        end else begin
            state_r   <= state_next_s;
            idx_r     <= idx_next_s;
            y_valid_r <= y_valid_next_s;
            wrap_r    <= wrap_next_s;
            y_r       <= y_next_s;
        end
    end

endmodule

// File: tb/tb_decoder_scan_nx2n.sv
// Directed self-checking bench for decoder_scan_nx2n (N=3, HOLD_W=8).
// Honours DEC_INV_OUT_EN so the same vectors cover the active-low build.
module tb_decoder_scan_nx2n;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    decoder_scan_nx2n_if #(.N(3), .HOLD_W(8)) bus ();

    decoder_scan_nx2n #(.N(3), .HOLD_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected pin value of y for a given valid flag and line index.
    function automatic logic [7:0] exp_y(input logic v, input int i);
        logic [7:0] t;
        t = v ? (8'h01 << i) : 8'h00;
`ifdef DEC_INV_OUT_EN
        t = ~t;
`endif
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.en = 1'b0; bus.mode = 1'b0; bus.sel_valid = 1'b0;
        bus.sel = 3'd0; bus.hold = 8'd1;
        tick(); tick();
        n_checks++; if (bus.y !== exp_y(1'b0, 0)) begin n_fail++; $display("FAIL reset_y: got %h expected %h", bus.y, exp_y(1'b0, 0)); end
        n_checks++; if (bus.y_valid !== 1'b0) begin n_fail++; $display("FAIL reset_y_valid: got %b expected 0", bus.y_valid); end
        n_checks++; if (bus.wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b expected 0", bus.wrap); end
        n_checks++; if (bus.idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx: got %0d expected 0", bus.idx); end
        n_checks++; if (bus.sel_ready !== 1'b0) begin n_fail++; $display("FAIL reset_sel_ready: got %b expected 0", bus.sel_ready); end
        rst = 1'b0;
    endtask

    task automatic test_direct();
        bus.en = 1'b1; bus.mode = 1'b0;
        #1;
        n_checks++; if (bus.sel_ready !== 1'b1) begin n_fail++; $display("FAIL direct_sel_ready: got %b expected 1", bus.sel_ready); end
        bus.sel = 3'd5; bus.sel_valid = 1'b1;
        tick();
        bus.sel_valid = 1'b0; bus.sel = 3'd2;
        n_checks++; if (bus.y !== exp_y(1'b1, 5)) begin n_fail++; $display("FAIL direct_y: got %h expected %h", bus.y, exp_y(1'b1, 5)); end
        n_checks++; if (bus.idx !== 3'd5) begin n_fail++; $display("FAIL direct_idx: got %0d expected 5", bus.idx); end
        n_checks++; if (bus.y_valid !== 1'b1) begin n_fail++; $display("FAIL direct_y_valid: got %b expected 1", bus.y_valid); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (bus.y !== exp_y(1'b1, 5) || bus.idx !== 3'd5) begin n_fail++; $display("FAIL direct_hold: got y=%h idx=%0d expected y=%h idx=5", bus.y, bus.idx, exp_y(1'b1, 5)); end
        end
    endtask

    task automatic test_back_to_back();
        bus.sel = 3'd1; bus.sel_valid = 1'b1;
        tick();
        bus.sel = 3'd7;
        n_checks++; if (bus.y !== exp_y(1'b1, 1) || bus.idx !== 3'd1) begin n_fail++; $display("FAIL b2b_first: got y=%h idx=%0d expected y=%h idx=1", bus.y, bus.idx, exp_y(1'b1, 1)); end
        tick();
        bus.sel_valid = 1'b0;
        n_checks++; if (bus.y !== exp_y(1'b1, 7) || bus.idx !== 3'd7) begin n_fail++; $display("FAIL b2b_second: got y=%h idx=%0d expected y=%h idx=7", bus.y, bus.idx, exp_y(1'b1, 7)); end
    endtask

    task automatic test_scan();
        int exp_idx;
        int wraps;
        bus.mode = 1'b1; bus.hold = 8'd3; bus.sel_valid = 1'b0;
        #1;
        n_checks++; if (bus.sel_ready !== 1'b0) begin n_fail++; $display("FAIL scan_sel_ready: got %b expected 0", bus.sel_ready); end
        tick();
        n_checks++; if (bus.y !== exp_y(1'b1, 0) || bus.idx !== 3'd0 || bus.y_valid !== 1'b1) begin n_fail++; $display("FAIL scan_entry: got y=%h idx=%0d v=%b expected y=%h idx=0 v=1", bus.y, bus.idx, bus.y_valid, exp_y(1'b1, 0)); end
        wraps = 0;
        for (int c = 1; c <= 26; c++) begin
            tick();
            exp_idx = (c / 3) % 8;
            n_checks++; if (bus.y !== exp_y(1'b1, exp_idx) || bus.idx !== exp_idx[2:0]) begin n_fail++; $display("FAIL scan_walk c=%0d: got y=%h idx=%0d expected y=%h idx=%0d", c, bus.y, bus.idx, exp_y(1'b1, exp_idx), exp_idx); end
            n_checks++; if (bus.wrap !== (c == 24)) begin n_fail++; $display("FAIL scan_wrap c=%0d: got %b expected %b", c, bus.wrap, (c == 24)); end
            n_checks++; if (bus.sel_ready !== 1'b0) begin n_fail++; $display("FAIL scan_ready c=%0d: got %b expected 0", c, bus.sel_ready); end
            if (bus.wrap === 1'b1) wraps++;
        end
        n_checks++; if (wraps != 1) begin n_fail++; $display("FAIL scan_wrap_count: got %0d expected 1", wraps); end
    endtask

    task automatic test_hold_zero();
        bus.mode = 1'b0;
        tick();
        n_checks++; if (bus.y_valid !== 1'b0 || bus.y !== exp_y(1'b0, 0)) begin n_fail++; $display("FAIL scan_exit: got y=%h v=%b expected y=%h v=0", bus.y, bus.y_valid, exp_y(1'b0, 0)); end
        bus.mode = 1'b1; bus.hold = 8'd0;
        tick();
        n_checks++; if (bus.idx !== 3'd0 || bus.y !== exp_y(1'b1, 0)) begin n_fail++; $display("FAIL hold0_entry: got y=%h idx=%0d expected idx=0", bus.y, bus.idx); end
        for (int c = 1; c <= 10; c++) begin
            if (c == 5) bus.hold = 8'd5;
            tick();
            n_checks++; if (bus.idx !== 3'(c % 8) || bus.y !== exp_y(1'b1, c % 8)) begin n_fail++; $display("FAIL hold0_step c=%0d: got y=%h idx=%0d expected idx=%0d", c, bus.y, bus.idx, c % 8); end
            n_checks++; if (bus.wrap !== (c == 8)) begin n_fail++; $display("FAIL hold0_wrap c=%0d: got %b expected %b", c, bus.wrap, (c == 8)); end
        end
    endtask

    task automatic test_drop_en();
        bus.mode = 1'b0;
        tick();
        bus.mode = 1'b1; bus.hold = 8'd1;
        tick();
        tick(); tick(); tick(); tick();
        n_checks++; if (bus.idx !== 3'd4) begin n_fail++; $display("FAIL drop_en_pre: got idx=%0d expected 4", bus.idx); end
        bus.en = 1'b0; bus.sel_valid = 1'b1; bus.sel = 3'd3;
        tick();
        n_checks++; if (bus.y !== exp_y(1'b0, 0) || bus.y_valid !== 1'b0) begin n_fail++; $display("FAIL drop_en_off: got y=%h v=%b expected y=%h v=0", bus.y, bus.y_valid, exp_y(1'b0, 0)); end
        n_checks++; if (bus.idx !== 3'd4) begin n_fail++; $display("FAIL drop_en_idx: got %0d expected 4", bus.idx); end
        n_checks++; if (bus.sel_ready !== 1'b0) begin n_fail++; $display("FAIL drop_en_ready: got %b expected 0", bus.sel_ready); end
        bus.sel_valid = 1'b0;
    endtask

    task automatic test_rst_mid_scan();
        bus.en = 1'b1; bus.mode = 1'b1; bus.hold = 8'd2;
        tick();
        tick(); tick(); tick();
        n_checks++; if (bus.idx !== 3'd1) begin n_fail++; $display("FAIL rst_mid_pre: got idx=%0d expected 1", bus.idx); end
        rst = 1'b1;
        tick();
        n_checks++; if (bus.y !== exp_y(1'b0, 0) || bus.y_valid !== 1'b0 || bus.idx !== 3'd0 || bus.wrap !== 1'b0) begin n_fail++; $display("FAIL rst_mid: got y=%h v=%b idx=%0d w=%b expected reset values", bus.y, bus.y_valid, bus.idx, bus.wrap); end
        rst = 1'b0;
    endtask

    task automatic test_scan_to_direct();
        bus.en = 1'b1; bus.mode = 1'b1; bus.hold = 8'd1;
        tick(); tick(); tick();
        n_checks++; if (bus.idx !== 3'd2) begin n_fail++; $display("FAIL s2d_pre: got idx=%0d expected 2", bus.idx); end
        bus.mode = 1'b0; bus.sel_valid = 1'b1; bus.sel = 3'd6;
        tick();
        bus.sel_valid = 1'b0;
        n_checks++; if (bus.y !== exp_y(1'b1, 6) || bus.idx !== 3'd6 || bus.y_valid !== 1'b1) begin n_fail++; $display("FAIL s2d_decode: got y=%h idx=%0d v=%b expected y=%h idx=6 v=1", bus.y, bus.idx, bus.y_valid, exp_y(1'b1, 6)); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_direct();
        test_back_to_back();
        test_scan();
        test_hold_zero();
        test_drop_en();
        test_rst_mid_scan();
        test_scan_to_direct();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
